ocp_sram_slave: RTL
===================

Name: ocp_sram_slave

Overview:
- OCP slave-side responder that terminates one fabric slave port in an on-chip single-port SRAM.
- Accepts one OCP request at a time, inserts a configurable number of wait states, then returns a single-cycle response (DVA or ERR) with read data.
- Counterpart to the ibus2ocp/dbus2ocp initiators; drops into any P<n> slot of fabric/fabric2 in place of memory_top.

Parameters:
- ADDR_BITS, 10, word-address width of the SRAM (depth = 2^ADDR_BITS words; default 4 KB).
- WAIT_STATES, 1, extra cycles inserted between request accept and SRAM access (0..15).
- DATA_WIDTH, `DATA_WIDTH (32), OCP data width.
- BEN_WIDTH, `BEN_WIDTH (4), OCP byte-enable width.

Ports:
- clk  in  1  system clock; everything on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_MAddr  in  `ADDR_WIDTH  byte address, port-relative.
- i_MCmd  in  3  OCP command (IDLE/WR/RD per ocp_const.vh).
- i_MData  in  DATA_WIDTH  write data.
- i_MByteEn  in  BEN_WIDTH  write byte enables.
- o_SCmdAccept  out  1  request accepted this cycle.
- o_SData  out  DATA_WIDTH  read data, valid with SResp=DVA on reads.
- o_SResp  out  2  OCP response (NULL/DVA/ERR).

Behaviour:
- Reset values: state=IDLE, o_SResp=NULL, o_SData=0, wait counter=0. o_SCmdAccept forced 0 while rst=1. SRAM contents are not reset.
- FSM states and transitions:
  - IDLE: o_SCmdAccept=1. If i_MCmd!=IDLE, latch cmd/addr/data/ben, load counter with WAIT_STATES, and go to WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES=0).
  - WAIT: o_SCmdAccept=0. Decrement counter; go to ACCESS when counter reaches 1.
  - ACCESS: perform the SRAM read/write using latched word address MAddr[ADDR_BITS+1:2]. Go to RESP.
  - RESP: drive o_SResp for exactly one cycle. Go to IDLE.
- Latency: response appears WAIT_STATES+2 cycles after the accept cycle. Next accept is possible in the cycle after RESP, so throughput is one transaction per WAIT_STATES+3 cycles.
- MCmd sampled only when o_SCmdAccept=1. The master holds MCmd until accepted; a command present while not in IDLE is not consumed.
- Writes: bytes with MByteEn[i]=1 are updated; MByteEn=0 writes nothing and still returns DVA. Writes are acknowledged with DVA (non-posted).
- Reads: o_SData is the SRAM word, registered on entry to RESP. o_SData returns to 0 on the cycle after RESP.
- Address handling: MAddr[1:0] ignored. Any nonzero bit in MAddr[`ADDR_WIDTH-1:ADDR_BITS+2] is out of range: no SRAM access, response ERR, o_SData=0. There is no aliasing.
- Unsupported MCmd values (3..7) are accepted, perform no SRAM access, and respond ERR.
- Reset mid-transaction:
  - Abort immediately; no response is issued after reset.
  - A write is committed only if reset arrives after its ACCESS cycle.
  - After rst deasserts, IDLE with o_SCmdAccept=1 on the first clock.
- o_SResp is NULL in every state except RESP.

Decomposition:
- Shared package/header ocp_const.vh holds MCmd codes (IDLE=0, WR=1, RD=2) and SResp codes (NULL=0, DVA=1, FAIL=2, ERR=3); add FSM state encodings there as OCP_SLV_* constants.
- One sub-module, ocp_sram_bank: single-port, byte-writable SRAM with 1-cycle synchronous read and no reset. The FSM stays in ocp_sram_slave.

Test Plan:
- WAIT_STATES=1: WR 0xDEADBEEF to 0x10 (ben 0xF), then RD 0x10. Accept at cycle 0, SResp=DVA at cycle 3 for each; read SData=0xDEADBEEF.
- Partial write to 0x10 with ben 0x2, data 0x0000AA00, then RD 0x10 -> DVA, SData=0xDEADAAEF. Write with ben 0x0 -> DVA, data unchanged.
- RD 0x1000 (out of range for ADDR_BITS=10) -> ERR at cycle 3, SData=0. Then WR 0x1000 -> ERR; RD 0x0 still returns its prior value (no alias).
- MCmd=3 at 0x20 -> accepted, ERR, no SRAM change; SCmdAccept=0 during WAIT/ACCESS/RESP while the master holds the next RD.
- Assert rst during WAIT of WR 0x30 -> SResp stays NULL, RD 0x30 returns the old value, SCmdAccept=1 on the first cycle after rst drops.
- WAIT_STATES=0: back-to-back RDs at 0x0, 0x4 -> SResp=DVA 2 cycles after each accept; accepts spaced 3 cycles apart.

Source files
------------

// File: rtl/ocp_sram_slave_pkg.sv
// Shared OCP constants and responder FSM state encoding for the SRAM slave.
package ocp_sram_slave_pkg;

  localparam int OCP_ADDR_WIDTH = 32;
  localparam int OCP_DATA_WIDTH = 32;
  localparam int OCP_BEN_WIDTH  = 4;

  localparam logic [2:0] OCP_MCMD_IDLE = 3'd0;
  localparam logic [2:0] OCP_MCMD_WR   = 3'd1;
  localparam logic [2:0] OCP_MCMD_RD   = 3'd2;

  localparam logic [1:0] OCP_SRESP_NULL = 2'd0;
  localparam logic [1:0] OCP_SRESP_DVA  = 2'd1;
  localparam logic [1:0] OCP_SRESP_FAIL = 2'd2;
  localparam logic [1:0] OCP_SRESP_ERR  = 2'd3;

  typedef enum logic [1:0] {
    OCP_SLV_IDLE   = 2'd0,
    OCP_SLV_WAIT   = 2'd1,
    OCP_SLV_ACCESS = 2'd2,
    OCP_SLV_RESP   = 2'd3
  } ocp_slv_state_e;

endpackage

// File: rtl/ocp_sram_bank.sv
// Single-port byte-writable SRAM, one-cycle synchronous read, contents not reset.
module ocp_sram_bank #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BEN_WIDTH-1:0]  ben,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BEN_WIDTH; i++) begin
          if (ben[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ocp_sram_slave.sv
// OCP slave responder: accepts one request, waits WAIT_STATES cycles, accesses
// the SRAM bank and returns a single-cycle DVA/ERR response.
module ocp_sram_slave
  import ocp_sram_slave_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1,
  parameter int DATA_WIDTH  = OCP_DATA_WIDTH,
  parameter int BEN_WIDTH   = OCP_BEN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OCP_ADDR_WIDTH-1:0] i_MAddr,
  input  logic [2:0]                i_MCmd,
  input  logic [DATA_WIDTH-1:0]     i_MData,
  input  logic [BEN_WIDTH-1:0]      i_MByteEn,
  output logic                      o_SCmdAccept,
  output logic [DATA_WIDTH-1:0]     o_SData,
  output logic [1:0]                o_SResp,
  output logic [1:0]                dbg_state
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  ocp_slv_state_e        state;
  logic [3:0]            wait_cnt;
  logic                  wr_q;
  logic                  rd_q;
  logic                  rd_valid;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BEN_WIDTH-1:0]  ben_q;
  logic [DATA_WIDTH-1:0] bank_rdata;
  logic                  in_range;
  logic                  unused_addr_lsbs;

  // Byte offset bits carry no meaning for a word-wide SRAM.
  assign unused_addr_lsbs = ^i_MAddr[1:0];
  assign in_range         = (i_MAddr[OCP_ADDR_WIDTH-1:ADDR_BITS+2] == '0);

  // Handshake: a request transfers in any cycle where i_MCmd != IDLE and
  // o_SCmdAccept = 1; the master holds the request until that cycle.
  assign o_SCmdAccept = (state == OCP_SLV_IDLE) && !rst;
  assign o_SData      = rd_valid ? bank_rdata : '0;
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OCP_SLV_IDLE;
      wait_cnt <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rd_valid <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ben_q    <= '0;
      o_SResp  <= OCP_SRESP_NULL;
    end else begin
      o_SResp  <= OCP_SRESP_NULL;
      rd_valid <= 1'b0;
      case (state)
        OCP_SLV_IDLE: begin
          if (i_MCmd != OCP_MCMD_IDLE) begin
            // wr_q/rd_q only flag legal in-range requests; anything else answers ERR
            wr_q     <= (i_MCmd == OCP_MCMD_WR) && in_range;
            rd_q     <= (i_MCmd == OCP_MCMD_RD) && in_range;
            addr_q   <= i_MAddr[ADDR_BITS+1:2];
            wdata_q  <= i_MData;
            ben_q    <= i_MByteEn;
            wait_cnt <= WAIT_LOAD;
            state    <= (WAIT_STATES == 0) ? OCP_SLV_ACCESS : OCP_SLV_WAIT;
          end
        end
        OCP_SLV_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state <= OCP_SLV_ACCESS;
        end
        OCP_SLV_ACCESS: begin
          o_SResp  <= (wr_q || rd_q) ? OCP_SRESP_DVA : OCP_SRESP_ERR;
          rd_valid <= rd_q;
          state    <= OCP_SLV_RESP;
        end
        OCP_SLV_RESP: state <= OCP_SLV_IDLE;
        default:      state <= OCP_SLV_IDLE;
      endcase
    end
  end

  ocp_sram_bank #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH),
    .BEN_WIDTH  (BEN_WIDTH)
  ) u_bank (
    .clk   (clk),
    .en    ((state == OCP_SLV_ACCESS) && (wr_q || rd_q)),
    .we    (wr_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .ben   (ben_q),
    .rdata (bank_rdata)
  );

endmodule
